// File: rtl/hall_emulator_pkg.sv
// Shared hall-sensor definitions: commutation sequence table,
// fault-mode encodings and index stepping helpers.
package hall_emulator_pkg;

    localparam int HALL_SEQ_LEN = 6;

    localparam logic [1:0] FM_NORMAL    = 2'b00;
    localparam logic [1:0] FM_FORCE_000 = 2'b01;
    localparam logic [1:0] FM_FORCE_111 = 2'b10;

    localparam logic [2:0] HALL_SEQ [HALL_SEQ_LEN] = '{
        3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101
    };

    localparam logic [2:0] HALL_IDX_LAST = 3'(HALL_SEQ_LEN - 1);

    // Hall code for a sequence index; out-of-range indices map to entry 0.
    function automatic logic [2:0] hall_code(input logic [2:0] idx);
        logic [2:0] code;
        code = HALL_SEQ[0];
        for (int i = 0; i < HALL_SEQ_LEN; i++) begin
            if (idx == 3'(i)) begin
                code = HALL_SEQ[i];
            end
        end
        return code;
    endfunction

    // Neighbouring sequence index, forward or backward, modulo the length.
    function automatic logic [2:0] hall_idx_next(
        input logic [2:0] idx,
        input logic       rev
    );
        logic [2:0] nxt;
        if (rev) begin
            nxt = (idx == 3'd0) ? HALL_IDX_LAST : idx - 3'd1;
        end else begin
            nxt = (idx >= HALL_IDX_LAST) ? 3'd0 : idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hall_emulator_phase_activity_monitor.sv
// Gate-drive front end: synchronizes H/L drives, flags a clean
// single-pair drive and any same-phase H+L overlap.
module phase_activity_monitor
    import hall_emulator_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] phase_h_i,
    input  logic [2:0] phase_l_i,
    output logic       valid_drive,
    output logic       shoot_pulse
);

    logic [2:0] h_s1_q, h_s1_d;
    logic [2:0] h_s2_q, h_s2_d;
    logic [2:0] l_s1_q, l_s1_d;
    logic [2:0] l_s2_q, l_s2_d;

    // Two-stage synchronizer next state.
    always_comb begin
        h_s1_d = phase_h_i;
        h_s2_d = h_s1_q;
        l_s1_d = phase_l_i;
        l_s2_d = l_s1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_s1_q <= '0;
            h_s2_q <= '0;
            l_s1_q <= '0;
            l_s2_q <= '0;
        end else begin
            h_s1_q <= h_s1_d;
            h_s2_q <= h_s2_d;
            l_s1_q <= l_s1_d;
            l_s2_q <= l_s2_d;
        end
    end

    // One high side and one low side on different phases energizes a pair.
    always_comb begin
        valid_drive = $onehot(h_s2_q) && $onehot(l_s2_q)
                   && ((h_s2_q & l_s2_q) == 3'b000);
        shoot_pulse = |(h_s2_q & l_s2_q);
    end

endmodule

// File: rtl/hall_emulator.sv
// Synthetic BLDC motor: steps the hall code while the driver energizes
// a valid phase pair, and injects hall fault codes on request.
module hall_emulator
    import hall_emulator_pkg::*;
#(
    parameter int STEP_PERIOD_WIDTH = 16,
    parameter int STEP_CNT_WIDTH    = 16,
    parameter bit REVERSE           = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [2:0]                   phaseH,
    input  logic [2:0]                   phaseL,
    input  logic [STEP_PERIOD_WIDTH-1:0] step_period,
    input  logic [1:0]                   fault_mode,
    output logic [2:0]                   hall,
    output logic [STEP_CNT_WIDTH-1:0]    step_cnt,
    output logic                         shoot_through
);

    logic valid_drive;
    logic shoot_pulse;

    phase_activity_monitor u_mon (
        .clk         (clk),
        .rst_n       (rst_n),
        .phase_h_i   (phaseH),
        .phase_l_i   (phaseL),
        .valid_drive (valid_drive),
        .shoot_pulse (shoot_pulse)
    );

    logic [STEP_PERIOD_WIDTH-1:0] timer_q, timer_d;
    logic                         active_q, active_d;
    logic [2:0]                   idx_q, idx_d;
    logic                         step_q, step_d;
    logic [STEP_CNT_WIDTH-1:0]    step_cnt_q, step_cnt_d;
    logic                         shoot_q, shoot_d;
    logic [2:0]                   hall_q, hall_d;

    logic running;
    logic terminal;

    // Step timer, activity tracking and position advance.
    always_comb begin
        running  = en && (step_period != '0);
        terminal = running && (timer_q >= step_period - 1'b1);
        step_d   = terminal && (active_q || valid_drive);

        timer_d  = '0;
        active_d = 1'b0;
        idx_d    = idx_q;
        if (en) begin
            if (running && !terminal) begin
                timer_d = timer_q + 1'b1;
            end
            if (!terminal) begin
                active_d = active_q || valid_drive;
            end
            if (step_d) begin
                idx_d = hall_idx_next(idx_q, REVERSE);
            end
        end
    end

    // Counter, sticky shoot-through flag and hall output mux.
    always_comb begin
        step_cnt_d = step_cnt_q + STEP_CNT_WIDTH'(step_q);
        shoot_d    = en && (shoot_q || shoot_pulse);
        if (fault_mode == FM_FORCE_000) begin
            hall_d = 3'b000;
        end else if (fault_mode == FM_FORCE_111) begin
            hall_d = 3'b111;
        end else begin
            hall_d = hall_code(idx_q);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            active_q   <= 1'b0;
            idx_q      <= 3'd0;
            step_q     <= 1'b0;
            step_cnt_q <= '0;
            shoot_q    <= 1'b0;
            hall_q     <= HALL_SEQ[0];
        end else begin
            timer_q    <= timer_d;
            active_q   <= active_d;
            idx_q      <= idx_d;
            step_q     <= step_d;
            step_cnt_q <= step_cnt_d;
            shoot_q    <= shoot_d;
            hall_q     <= hall_d;
        end
    end

    assign hall          = hall_q;
    assign step_cnt      = step_cnt_q;
    assign shoot_through = shoot_q;

endmodule

// File: tb/tb_hall_emulator.sv
// Self-checking bench for hall_emulator: forward and reverse
// instances compared each cycle against a rotor model.
module tb_hall_emulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  phaseH = '0;
    logic [2:0]  phaseL = '0;
    logic [15:0] step_period = '0;
    logic [1:0]  fault_mode = '0;

    logic [2:0]  hall_f, hall_r;
    logic [15:0] cnt_f, cnt_r;
    logic        st_f, st_r;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hall_emulator #(.REVERSE(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .en(en),
        .phaseH(phaseH), .phaseL(phaseL),
        .step_period(step_period), .fault_mode(fault_mode),
        .hall(hall_f), .step_cnt(cnt_f), .shoot_through(st_f)
    );

    hall_emulator #(.REVERSE(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .en(en),
        .phaseH(phaseH), .phaseL(phaseL),
        .step_period(step_period), .fault_mode(fault_mode),
        .hall(hall_r), .step_cnt(cnt_r), .shoot_through(st_r)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h expected=%0h t=%0t",
                         name, act, exp, $time);
        end
    endtask

    // ---------------- rotor model ----------------
    logic [2:0] seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    int          m_elapsed;
    bit          m_powered;
    bit          m_st;
    int          m_pos;
    logic [15:0] m_cnt;
    bit          m_pend;
    logic [2:0]  m_h [2];
    logic [2:0]  m_l [2];
    logic [2:0]  m_hall_f, m_hall_r;
    bit          m_vd, m_term, m_step;

    function automatic logic [2:0] shown(input logic [1:0] fm,
                                         input logic [2:0] code);
        if (fm == 2'b01) return 3'b000;
        if (fm == 2'b10) return 3'b111;
        return code;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_elapsed = 0; m_powered = 0; m_st = 0; m_pos = 0;
            m_cnt = 0; m_pend = 0;
            m_h[0] = 0; m_h[1] = 0; m_l[0] = 0; m_l[1] = 0;
            m_hall_f = 3'b001; m_hall_r = 3'b001;
        end else begin
            m_vd = ($countones(m_h[1]) == 1) && ($countones(m_l[1]) == 1)
                && ((m_h[1] & m_l[1]) == 0);
            m_hall_f = shown(fault_mode, seq[m_pos]);
            m_hall_r = shown(fault_mode, seq[(6 - m_pos) % 6]);
            if (m_pend) m_cnt = m_cnt + 16'd1;
            m_pend = 0;
            if (!en) begin
                m_elapsed = 0; m_powered = 0; m_st = 0;
            end else begin
                if ((m_h[1] & m_l[1]) != 0) m_st = 1;
                m_term = (step_period != 0)
                      && (m_elapsed >= int'(step_period) - 1);
                m_step = m_term && (m_powered || m_vd);
                if (m_term) begin
                    m_elapsed = 0; m_powered = 0;
                end else begin
                    m_elapsed = (step_period != 0) ? m_elapsed + 1 : 0;
                    m_powered = m_powered || m_vd;
                end
                if (m_step) begin
                    m_pos = (m_pos + 1) % 6;
                    m_pend = 1;
                end
            end
            m_h[1] = m_h[0]; m_h[0] = phaseH;
            m_l[1] = m_l[0]; m_l[0] = phaseL;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("hall_fwd", 32'(hall_f), 32'(m_hall_f));
            check("hall_rev", 32'(hall_r), 32'(m_hall_r));
            check("cnt_fwd", 32'(cnt_f), 32'(m_cnt));
            check("cnt_rev", 32'(cnt_r), 32'(m_cnt));
            check("st_fwd", 32'(st_f), 32'(m_st));
            check("st_rev", 32'(st_r), 32'(m_st));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; phaseH = '0; phaseL = '0;
        step_period = '0; fault_mode = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit hit;
        // reset state
        do_reset();
        check("rst_hall", 32'(hall_f), 32'h1);
        check("rst_cnt", 32'(cnt_f), 32'h0);
        check("rst_st", 32'(st_f), 32'h0);

        // forward/reverse walk at period 10
        en = 1; step_period = 10; phaseH = 3'b001; phaseL = 3'b010;
        repeat (35) @(negedge clk);
        check("walk_hall_fwd", 32'(hall_f), 32'h6);
        check("walk_hall_rev", 32'(hall_r), 32'h6);
        check("walk_cnt", 32'(cnt_f), 32'd3);

        // unpowered rotor and stalled rotor
        do_reset();
        en = 1; step_period = 10;
        repeat (50) @(negedge clk);
        check("idle_hall", 32'(hall_f), 32'h1);
        check("idle_cnt", 32'(cnt_f), 32'd0);
        step_period = 0; phaseH = 3'b001; phaseL = 3'b010;
        repeat (30) @(negedge clk);
        check("stall_cnt", 32'(cnt_f), 32'd0);
        check("stall_hall", 32'(hall_f), 32'h1);

        // period 4, reverse wrap
        do_reset();
        en = 1; step_period = 4; phaseH = 3'b100; phaseL = 3'b001;
        repeat (6) @(negedge clk);
        check("p4_rev_1", 32'(hall_r), 32'h5);
        check("p4_fwd_1", 32'(hall_f), 32'h3);
        repeat (20) @(negedge clk);
        check("p4_cnt_6", 32'(cnt_f), 32'd6);
        check("p4_rev_6", 32'(hall_r), 32'h1);

        // shoot-through
        do_reset();
        en = 1; phaseH = 3'b001; phaseL = 3'b001;
        @(negedge clk);
        phaseH = 3'b000; phaseL = 3'b000;
        @(negedge clk);
        check("st_early", 32'(st_f), 32'h0);
        @(negedge clk);
        check("st_set", 32'(st_f), 32'h1);
        repeat (5) @(negedge clk);
        check("st_sticky", 32'(st_f), 32'h1);
        en = 0;
        @(negedge clk);
        en = 1;
        check("st_clear", 32'(st_f), 32'h0);

        // fault injection mid-rotation
        do_reset();
        en = 1; step_period = 10; phaseH = 3'b010; phaseL = 3'b100;
        repeat (25) @(negedge clk);
        fault_mode = 2'b01;
        @(negedge clk);
        check("fm_000_f", 32'(hall_f), 32'h0);
        check("fm_000_r", 32'(hall_r), 32'h0);
        repeat (10) @(negedge clk);
        fault_mode = 2'b10;
        @(negedge clk);
        check("fm_111", 32'(hall_f), 32'h7);
        repeat (10) @(negedge clk);
        fault_mode = 2'b00;
        @(negedge clk);
        check("fm_back_f", 32'(hall_f), 32'h4);
        check("fm_back_r", 32'(hall_r), 32'h2);
        check("fm_cnt", 32'(cnt_f), 32'd4);

        // counter wrap at period 1, then async reset mid-period
        do_reset();
        en = 1; step_period = 1; phaseH = 3'b001; phaseL = 3'b100;
        hit = 0;
        for (int i = 0; i < 70000 && !hit; i++) begin
            @(negedge clk);
            if (cnt_f == 16'hFFFF) hit = 1;
        end
        check("wrap_reach", 32'(hit), 32'h1);
        @(negedge clk);
        check("wrap_zero", 32'(cnt_f), 32'h0);
        step_period = 10;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hall", 32'(hall_f), 32'h1);
        check("arst_cnt", 32'(cnt_f), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hall_emulator.md
# hall_emulator

Synthetic motor/hall-sensor source for bench and in-FPGA self-test of the BLDC motor driver. Consumes the six gate-drive lines the driver produces and returns a 3-bit hall code that advances through the standard 120° commutation sequence whenever the driver is actively energizing a valid phase pair. It also flags shoot-through and injects the hall fault codes (000 and 111) the driver must detect. It sits between a driver instance's `phaseH`/`phaseL` outputs and its `hall` input, in place of the physical motor.

## Interface
- `STEP_PERIOD_WIDTH`, 16: width of the step-period input and timer.
- `STEP_CNT_WIDTH`, 16: width of the step counter output.
- `REVERSE`, 0: 0 walks the sequence forward, 1 walks it backward.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `en`  in  1  emulator enable. Low freezes position and clears the timer, activity flag and shoot-through flag.
- `phaseH`  in  3  high-side gate drives from the driver.
- `phaseL`  in  3  low-side gate drives from the driver.
- `step_period`  in  STEP_PERIOD_WIDTH  clocks per commutation step. 0 means stalled rotor.
- `fault_mode`  in  2  00 normal, 01 force 000, 10 force 111, 11 normal.
- `hall`  out  3  emulated hall code, registered.
- `step_cnt`  out  STEP_CNT_WIDTH  number of steps taken, wrapping.
- `shoot_through`  out  1  sticky flag: some phase had H and L high in the same cycle.

## Operation
- Sequence, index 0..5: 001, 011, 010, 110, 100, 101. Forward: index+1 mod 6. Reverse: index−1 mod 6.
- Inputs `phaseH`/`phaseL` pass through a 2-flop synchronizer. All checks use the synchronized values.
- Valid-drive cycle:
  - exactly one bit of synced H is set,
  - exactly one bit of synced L is set,
  - they are on different phases.
- Activity flag: set on any valid-drive cycle. Cleared at each timer terminal.
- Step timer:
  - counts 0..`step_period`−1 while `en`=1 and `step_period`≠0.
  - Terminal condition is timer ≥ `step_period`−1. The timer then returns to 0.
  - At terminal, if the activity flag is set, or a valid-drive cycle occurs in the terminal cycle itself:
    - index advances,
    - `step_cnt` increments, wrapping from all-ones to 0.
  - Otherwise the index holds (unpowered rotor does not turn).
- `step_period`=0: timer held at 0, no steps taken.
- `shoot_through`: set on any cycle where synced H[j]&L[j] for some j. Cleared only by `en`=0 or reset.
- `hall` output:
  - fault_mode 01 → 000.
  - fault_mode 10 → 111.
  - otherwise → sequence[index].
- `en`=0:
  - index and `step_cnt` hold,
  - timer, activity flag and `shoot_through` are cleared,
  - `hall` keeps tracking `fault_mode` and index.
- Reset values: index 0, `hall`=001, `step_cnt`=0, `shoot_through`=0, timer 0, activity 0, synchronizers 0.

## Timing
- Phase input to internal use: 2 cycles.
- `shoot_through` asserts 3 cycles after the offending input edge.
- Terminal cycle at clock edge N: new index registered at N. `hall` and `step_cnt` reflect it at N+1.
- `fault_mode` change to `hall`: 1 cycle.
- `en` falling in a terminal cycle: `en` wins. No step, timer cleared.
- `step_period` lowered below the current timer value: terminal on the next cycle (≥ compare). No wrap-around through the full counter range.
- Reset asserted mid-step: all state clears immediately, asynchronously. Deassertion is synchronized by the system-level reset bridge.

## Structure
- Shared package:
  - hall sequence table (6×3 constants),
  - `fault_mode` encodings (`FM_NORMAL`, `FM_FORCE_000`, `FM_FORCE_111`),
  - `HALL_SEQ_LEN`=6.
- The same package is later used by a hall decoder. No duplicate tables.
- One sub-module: `phase_activity_monitor`.
  - Contains the synchronizer, valid-drive detect and shoot-through detect.
  - Outputs `valid_drive` and `shoot_pulse`.
- Top level holds the timer, index, counter and output mux.

## Test plan
- Reset, `en`=1, `step_period`=10, H=001 and L=010 held → `hall` walks 001→011→010→110 every 10 cycles. `step_cnt`=3 after 30 cycles plus pipeline delay.
- Same as above with H=L=000 → `hall` stays 001 and `step_cnt`=0 indefinitely. Then `step_period`=0 with a valid drive → still no steps.
- `REVERSE`=1, valid drive, period 4 → sequence 001→101→100→110. Index wraps 0→5 correctly.
- H=001, L=001 for one cycle → `shoot_through`=1 three cycles later and stays set. A pulse of `en`=0 clears it.
- `fault_mode`=01 then 10 mid-rotation → `hall`=000, then 111, one cycle after each change. Returning to 00 restores the advanced sequence value; index kept counting throughout.
- `step_cnt` preset near all-ones by running 65535 steps at period 1 → next step wraps to 0. `rst_n` pulsed low mid-period → `hall`=001 and `step_cnt`=0 immediately.
